// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//
// SPI mode-0 master that reads a contiguous byte range from a serial NOR flash
// and streams the received bytes to fabric logic. Issues Read (0x03) with a
// 24-bit address, single-bit I/O, MSB first.
//
// Build option: define FAST_READ_EN to issue Fast Read (0x0B) with 8 dummy
// clocks between the address and the data phase.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (>= 1), SCLK = clk / (2*CLK_DIV)
//   LEN_W    width of the byte-count input
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request pulse, sampled only while busy = 0
//   addr      flash start address, captured with start
//   len       number of bytes to read, captured with start (0 = no transfer)
//   busy      high from the cycle after acceptance through the CS-high guard
//   done      one-cycle pulse at transaction end
//   rd_data   received byte, valid while rd_valid = 1
//   rd_valid  one-cycle pulse per received byte, no backpressure
//   cson      flash chip select, active low
//   sclk      SPI clock, idles low
//   sdo       master-out data
//   sdi       master-in data

module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             cson,
  output logic             sclk,
  output logic             sdo,
  input  logic             sdi
);

  // One counter serves the sclk half-period, the CS tail and the guard time.
  localparam int unsigned CntW = $clog2(2 * CLK_DIV);
  localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(2 * CLK_DIV - 1);

`ifdef FAST_READ_EN
  localparam logic [7:0] Cmd = 8'h0B;
`else
  localparam logic [7:0] Cmd = 8'h03;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
`ifdef FAST_READ_EN
    StDummy,
`endif
    StData,
    StTail,
    StGuard
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cson_q, cson_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [31:0]       shout_q, shout_d;
  logic [7:0]        shin_q, shin_d;
  logic [LEN_W-1:0]  bytes_q, bytes_d;
  logic              byte_rdy_q, byte_rdy_d;

  logic              half_tick;
  logic              fall;
  logic [CntW-1:0]   cnt_step;

  assign half_tick = (cnt_q == HalfLast);
  // A falling sclk edge is the end of a high phase: sdi is sampled and sdo
  // advances on this same clk edge, so sdo only ever changes while sclk is low.
  assign fall      = half_tick & sclk_q;
  assign cnt_step  = half_tick ? '0 : cnt_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    cson_d     = cson_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shout_d    = shout_q;
    shin_d     = shin_q;
    bytes_d    = bytes_q;
    byte_rdy_d = 1'b0;
    // A completed byte is published one cycle after its last sample.
    rd_valid_d = byte_rdy_q;
    rd_data_d  = byte_rdy_q ? shin_q : rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d = StCmd;
            cnt_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            cson_d  = 1'b0;
            busy_d  = 1'b1;
            shout_d = {Cmd, addr};
            bytes_d = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StCmd: begin
        cnt_d  = cnt_step;
        sclk_d = sclk_q ^ half_tick;
        if (fall) begin
          shout_d = {shout_q[30:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d   = '0;
            state_d = StAddr;
          end
        end
      end

      StAddr: begin
        cnt_d  = cnt_step;
        sclk_d = sclk_q ^ half_tick;
        if (fall) begin
          // Zero fill leaves sdo low for the dummy and data phases.
          shout_d = {shout_q[30:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          if (bit_q == 5'd23) begin
            bit_d   = '0;
`ifdef FAST_READ_EN
            state_d = StDummy;
`else
            state_d = StData;
`endif
          end
        end
      end

`ifdef FAST_READ_EN
      StDummy: begin
        cnt_d  = cnt_step;
        sclk_d = sclk_q ^ half_tick;
        if (fall) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d   = '0;
            state_d = StData;
          end
        end
      end
`endif

      StData: begin
        cnt_d  = cnt_step;
        sclk_d = sclk_q ^ half_tick;
        if (fall) begin
          shin_d = {shin_q[6:0], sdi};
          bit_d  = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d      = '0;
            byte_rdy_d = 1'b1;
            bytes_d    = bytes_q - LEN_W'(1);
            if (bytes_q == LEN_W'(1)) begin
              state_d = StTail;
            end
          end
        end
      end

      StTail: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_tick) begin
          cnt_d   = '0;
          cson_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StGuard;
        end
      end

      StGuard: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == GuardLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      cson_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      shout_q    <= '0;
      shin_q     <= '0;
      bytes_q    <= '0;
      byte_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      cson_q     <= cson_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      shout_q    <= shout_d;
      shin_q     <= shin_d;
      bytes_q    <= bytes_d;
      byte_rdy_q <= byte_rdy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign cson     = cson_q;
  assign sclk     = sclk_q;
  assign sdo      = shout_q[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances with CLK_DIV = 2, 1, 3 share one
// behavioural flash model. Expected bytes are queued at start and popped on
// each rd_valid; sclk, rd_valid, done and busy timing are checked against the
// cycle formulas. Outside the last cycle of each sclk high phase the flash
// model drives the inverted bit, so a mistimed sample shows up as bad data.

module tb_spi_flash_reader;

  localparam int NI = 3;
  localparam int LW = 16;
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         HDR = 40;
  localparam int         NV  = 5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         HDR = 32;
  localparam int         NV  = 5;
`endif

  typedef struct {
    int          inst;
    logic [23:0] addr;
    int          len;
    int          glitch;
    int          done_cyc;
    int          bfall_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start    [NI];
  logic [23:0]   addr     [NI];
  logic [LW-1:0] len      [NI];
  logic          busy     [NI];
  logic          done     [NI];
  logic [7:0]    rd_data  [NI];
  logic          rd_valid [NI];
  logic          cson     [NI];
  logic          sclk     [NI];
  logic          sdo      [NI];
  logic          sdi      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    spi_flash_reader #(
      .CLK_DIV(D),
      .LEN_W  (LW)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start[g]),
      .addr    (addr[g]),
      .len     (len[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rd_data (rd_data[g]),
      .rd_valid(rd_valid[g]),
      .cson    (cson[g]),
      .sclk    (sclk[g]),
      .sdo     (sdo[g]),
      .sdi     (sdi[g])
    );
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t0        [NI];
  int          rises     [NI];
  int          last_rise [NI];
  int          nval      [NI];
  int          ndone     [NI];
  int          done_rel  [NI];
  int          bfall_rel [NI];
  int          sdo_bad   [NI];
  int          m0_bad    [NI];
  logic [31:0] cmd_addr  [NI];
  logic [23:0] cur_addr  [NI];
  logic        prev_sclk [NI];
  logic        prev_sdo  [NI];
  logic        prev_busy [NI];
  logic [7:0]  exp_q[$];
  vec_t        vecs[NV];

  function automatic int div_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  function automatic logic [7:0] fbyte(logic [23:0] a);
    case (a)
      24'h123456: return 8'hA5;
      24'h123457: return 8'h5A;
      24'h123458: return 8'hFF;
      24'h123459: return 8'h00;
      24'h000100: return 8'h3C;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h6C;
    endcase
  endfunction

  function automatic logic bit_of(int i, int k);
    logic [7:0] b;
    int         off;
    if (k < HDR) return 1'b0;
    off = k - HDR;
    b   = fbyte(cur_addr[i] + 24'(off / 8));
    return b[7 - (off % 8)];
  endfunction

  function automatic int exp_done(int i, int l);
    int d;
    d = div_of(i);
    return 1 + 2 * d * (HDR + 8 * l) + d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: observe all instances at the falling clk edge and drive
  // the flash model's sdi for the rest of the cycle.
  task automatic tick();
    int   rel;
    int   d;
    logic b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      d   = div_of(i);
      rel = cyc - t0[i];
      if (sclk[i] && !prev_sclk[i]) begin
        chk("sclk_rise_cyc", 32'(rel), 32'(1 + d + 2 * d * rises[i]));
        if (rises[i] < 32) cmd_addr[i] = {cmd_addr[i][30:0], sdo[i]};
        else if (sdo[i]) sdo_bad[i]++;
        last_rise[i] = rel;
        rises[i]++;
      end
      if (sclk[i] && (sdo[i] !== prev_sdo[i])) m0_bad[i]++;
      if (rd_valid[i]) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 32'(rd_valid[i]), 32'(0));
        end else begin
          chk("rd_data", 32'(rd_data[i]), 32'(exp_q.pop_front()));
          chk("rd_valid_cyc", 32'(rel), 32'(2 + 2 * d * (HDR + 8 * (nval[i] + 1))));
        end
        nval[i]++;
      end
      if (done[i]) begin
        ndone[i]++;
        done_rel[i] = rel;
      end
      if (prev_busy[i] && !busy[i]) bfall_rel[i] = rel;
      prev_sclk[i] = sclk[i];
      prev_sdo[i]  = sdo[i];
      prev_busy[i] = busy[i];
      if (sclk[i] && (rel - last_rise[i] == d - 1)) begin
        sdi[i] = bit_of(i, rises[i] - 1);
      end else begin
        b      = bit_of(i, sclk[i] ? rises[i] - 1 : rises[i]);
        sdi[i] = ~b;
      end
    end
  endtask

  // Called right after tick(): this cycle becomes cycle 0.
  task automatic pulse_start(int i, logic [23:0] a, int l);
    addr[i]      = a;
    len[i]       = LW'(l);
    start[i]     = 1'b1;
    t0[i]        = cyc;
    rises[i]     = 0;
    last_rise[i] = 0;
    nval[i]      = 0;
    ndone[i]     = 0;
    done_rel[i]  = 0;
    bfall_rel[i] = 0;
    sdo_bad[i]   = 0;
    m0_bad[i]    = 0;
    cmd_addr[i]  = '0;
    cur_addr[i]  = a;
    for (int j = 0; j < l; j++) exp_q.push_back(fbyte(a + 24'(j)));
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic run_xfer(vec_t v);
    int i;
    i = v.inst;
    pulse_start(i, v.addr, v.len);
    for (int c = 0; c < v.bfall_cyc + 40; c++) begin
      tick();
      if (v.glitch != 0 && (cyc - t0[i]) == v.glitch) begin
        // A second request while busy must be dropped, not queued.
        addr[i]  = ~v.addr;
        len[i]   = LW'(5);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
      end
      if (bfall_rel[i] != 0) break;
    end
    chk("xfer_finished", 32'(bfall_rel[i] != 0), 32'(1));
    chk("sclk_pulses", 32'(rises[i]), 32'(HDR + 8 * v.len));
    chk("cmd_addr_on_sdo", cmd_addr[i], {CMD, v.addr});
    chk("sdo_nonzero_after_addr", 32'(sdo_bad[i]), 32'(0));
    chk("sdo_toggled_sclk_high", 32'(m0_bad[i]), 32'(0));
    chk("rd_valid_count", 32'(nval[i]), 32'(v.len));
    chk("done_count", 32'(ndone[i]), 32'(1));
    chk("done_cyc", 32'(done_rel[i]), 32'(v.done_cyc));
    chk("busy_fall_cyc", 32'(bfall_rel[i]), 32'(v.bfall_cyc));
    chk("bytes_outstanding", 32'(exp_q.size()), 32'(0));
    chk("cson_after", 32'(cson[i]), 32'(1));
  endtask

  initial begin
    vec_t v;
    int   rst_rel;
`ifdef FAST_READ_EN
    vecs[0] = '{1, 24'h000100, 1, 0, 98, 100};
    vecs[1] = '{0, 24'h123456, 4, 0, 291, 295};
    vecs[2] = '{0, 24'h0A0B0C, 2, 20, 227, 231};
    vecs[3] = '{0, 24'h00ABCD, 3, 0, 259, 263};
    vecs[4] = '{2, 24'hFFFFFE, 3, 0, 388, 394};
`else
    vecs[0] = '{0, 24'h123456, 4, 0, 259, 263};
    vecs[1] = '{0, 24'h0A0B0C, 2, 20, 195, 199};
    vecs[2] = '{0, 24'h00ABCD, 3, 0, 227, 231};
    vecs[3] = '{1, 24'h000100, 1, 0, 82, 84};
    vecs[4] = '{2, 24'hFFFFFE, 3, 0, 340, 346};
`endif
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      addr[i]      = '0;
      len[i]       = '0;
      sdi[i]       = 1'b0;
      t0[i]        = 0;
      rises[i]     = 0;
      last_rise[i] = 0;
      nval[i]      = 0;
      ndone[i]     = 0;
      done_rel[i]  = 0;
      bfall_rel[i] = 0;
      sdo_bad[i]   = 0;
      m0_bad[i]    = 0;
      cmd_addr[i]  = '0;
      cur_addr[i]  = '0;
      prev_sclk[i] = 1'b0;
      prev_sdo[i]  = 1'b0;
      prev_busy[i] = 1'b0;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_cson", 32'(cson[i]), 32'(1));
      chk("reset_sclk", 32'(sclk[i]), 32'(0));
      chk("reset_sdo", 32'(sdo[i]), 32'(0));
      chk("reset_busy", 32'(busy[i]), 32'(0));
      chk("reset_done", 32'(done[i]), 32'(0));
      chk("reset_rd_valid", 32'(rd_valid[i]), 32'(0));
      chk("reset_rd_data", 32'(rd_data[i]), 32'(0));
    end
    rst_n = 1'b1;
    repeat (3) tick();

    for (int n = 0; n < NV; n++) run_xfer(vecs[n]);

    // len = 0: done on cycle 1, no bus activity.
    tick();
    pulse_start(0, 24'h000010, 0);
    tick();
    chk("len0_done", 32'(done[0]), 32'(1));
    chk("len0_cson", 32'(cson[0]), 32'(1));
    chk("len0_busy", 32'(busy[0]), 32'(0));
    repeat (10) tick();
    chk("len0_done_count", 32'(ndone[0]), 32'(1));
    chk("len0_done_cyc", 32'(done_rel[0]), 32'(1));
    chk("len0_sclk_pulses", 32'(rises[0]), 32'(0));
    chk("len0_rd_valid", 32'(nval[0]), 32'(0));

    // Reset in the middle of byte 2 of an 8-byte read.
    tick();
    pulse_start(0, 24'h00BEEF, 8);
    rst_rel = 1 + 4 * (HDR + 20);
    for (int c = 0; c < rst_rel + 10; c++) begin
      tick();
      if (cyc - t0[0] == rst_rel) break;
    end
    chk("rst_reached_data", 32'(cyc - t0[0]), 32'(rst_rel));
    chk("rst_in_data_sclk_seen", 32'(rises[0]), 32'(HDR + 20));
    rst_n = 1'b0;
    #1;
    chk("rst_cson", 32'(cson[0]), 32'(1));
    chk("rst_sclk", 32'(sclk[0]), 32'(0));
    chk("rst_busy", 32'(busy[0]), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid[0]), 32'(0));
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rst_no_done", 32'(ndone[0]), 32'(0));
    chk("rst_bytes_before", 32'(nval[0]), 32'(2));
    v = '{0, 24'h00BEEF, 8, 0, exp_done(0, 8), exp_done(0, 8) + 4};
    run_xfer(v);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
